ss_stream_src: RTL and testbench

- DMA-channel-side driver of the stream-slave (ss_*) port. It is the initiator/transmitter end that feeds endpoint engines (ports 2/3).
- Accepts one descriptor (word count plus 24-bit dc control), waits for the endpoint's ss_start, then streams 32-bit words from the channel read FIFO with ss_xfer/ss_last.
- Honours ss_stop backpressure, waits for ss_end, captures the endpoint's returned result word, and reports completion status to the channel controller.

---
 rtl/ss_stream_src.sv | 211 +++++++++++++++++++++
 tb/tb_ss_stream_src.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_stream_src.sv
// ss_stream_src: DMA-channel driver of the stream-slave (ss_*) port.
// Takes one descriptor, waits for ss_start, streams FIFO words with ss_xfer/ss_last,
// waits for ss_end, captures the result word and reports completion status.
// Optional feature macro: SS_TIMEOUT_EN bounds WAIT_START/WAIT_END to TIMEOUT_CYC cycles.
module ss_stream_src #(
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             desc_valid,
    output logic             desc_ready,
    input  logic [LEN_W-1:0] desc_len,
    input  logic [23:0]      desc_dc,
    input  logic             abort_i,
    input  logic [31:0]      fifo_dat,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    input  logic             ss_start,
    input  logic             ss_stop,
    input  logic             ss_end,
    input  logic [31:0]      wbs_dat_i,
    output logic             ss_xfer,
    output logic             ss_last,
    output logic [31:0]      wbs_dat_o,
    output logic [23:0]      dc,
    output logic             m_reset,
    output logic             done_o,
    output logic [1:0]       status_o,
    output logic [31:0]      result_o
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_START = 3'd1,
        S_XFER       = 3'd2,
        S_WAIT_END   = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    // Elaboration guard: a timeout shorter than two cycles cannot be counted.
    if (TIMEOUT_CYC < 2) begin : g_tmo_chk
        $error("ss_stream_src: TIMEOUT_CYC must be at least 2");
    end

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              desc_ready_q, desc_ready_d;
    logic              ss_xfer_q, ss_xfer_d;
    logic              ss_last_q, ss_last_d;
    logic [31:0]       wbs_dat_q, wbs_dat_d;
    logic [23:0]       dc_q, dc_d;
    logic              m_reset_q, m_reset_d;
    logic              done_q, done_d;
    logic [1:0]        status_q, status_d;
    logic [31:0]       result_q, result_d;
    logic              pop_c;

`ifdef SS_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              tmo_hit_c;

    // Wait-state cycle counter; restarted whenever a wait state is entered.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) tmo_q <= '0;
        else          tmo_q <= tmo_d;
    end

    assign tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`endif

    // Pop only while streaming, data available, no backpressure, words left and no abort.
    assign pop_c   = (state_q == S_XFER) && !fifo_empty && !ss_stop &&
                     (cnt_q != '0) && !abort_i;
    assign fifo_rd = pop_c;

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ss_xfer_d = 1'b0;
        ss_last_d = 1'b0;
        wbs_dat_d = wbs_dat_q;
        dc_d      = dc_q;
        m_reset_d = 1'b0;
        status_d  = status_q;
        result_d  = result_q;
`ifdef SS_TIMEOUT_EN
        tmo_d     = tmo_q + TMO_W'(1);
`endif

        case (state_q)
            S_IDLE: begin
                if (desc_valid && desc_ready_q) begin
                    dc_d  = desc_dc;
                    cnt_d = desc_len;
                    if (desc_len == '0) begin
                        status_d = 2'b01;
                        state_d  = S_DONE;
                    end else begin
                        status_d = 2'b00;
                        state_d  = S_WAIT_START;
`ifdef SS_TIMEOUT_EN
                        tmo_d    = '0;
`endif
                    end
                end
            end
            S_WAIT_START: begin
                if (ss_start) begin
                    state_d = S_XFER;
                end
`ifdef SS_TIMEOUT_EN
                else if (tmo_hit_c) begin
                    m_reset_d = 1'b1;
                    status_d  = 2'b10;
                    state_d   = S_DONE;
                end
`endif
            end
            S_XFER: begin
                if (pop_c) begin
                    ss_xfer_d = 1'b1;
                    wbs_dat_d = fifo_dat;
                    ss_last_d = (cnt_q == LEN_W'(1));
                    cnt_d     = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_WAIT_END;
`ifdef SS_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end
            end
            S_WAIT_END: begin
                if (ss_end) begin
                    result_d = wbs_dat_i;
                    state_d  = S_DONE;
                end
`ifdef SS_TIMEOUT_EN
                else if (tmo_hit_c) begin
                    m_reset_d = 1'b1;
                    status_d  = 2'b10;
                    state_d   = S_DONE;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort outside IDLE overrides everything, including a same-cycle ss_end.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            m_reset_d = 1'b1;
            ss_xfer_d = 1'b0;
            ss_last_d = 1'b0;
            result_d  = result_q;
            status_d  = status_q;
            cnt_d     = cnt_q;
        end

        desc_ready_d = (state_d == S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            desc_ready_q <= 1'b1;
            ss_xfer_q    <= 1'b0;
            ss_last_q    <= 1'b0;
            wbs_dat_q    <= '0;
            dc_q         <= '0;
            m_reset_q    <= 1'b0;
            done_q       <= 1'b0;
            status_q     <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            desc_ready_q <= desc_ready_d;
            ss_xfer_q    <= ss_xfer_d;
            ss_last_q    <= ss_last_d;
            wbs_dat_q    <= wbs_dat_d;
            dc_q         <= dc_d;
            m_reset_q    <= m_reset_d;
            done_q       <= done_d;
            status_q     <= status_d;
            result_q     <= result_d;
        end
    end

    assign desc_ready = desc_ready_q;
    assign ss_xfer    = ss_xfer_q;
    assign ss_last    = ss_last_q;
    assign wbs_dat_o  = wbs_dat_q;
    assign dc         = dc_q;
    assign m_reset    = m_reset_q;
    assign done_o     = done_q;
    assign status_o   = status_q;
    assign result_o   = result_q;

endmodule

// File: tb/tb_ss_stream_src.sv
// Scoreboard bench for ss_stream_src: expected stream words are queued by the
// stimulus; a negedge monitor pops and compares on every ss_xfer.
module tb_ss_stream_src;

    localparam int unsigned LEN_W = 16;

    logic             wb_clk_i = 1'b0;
    logic             wb_rst_i;
    logic             desc_valid;
    logic             desc_ready;
    logic [LEN_W-1:0] desc_len;
    logic [23:0]      desc_dc;
    logic             abort_i;
    logic [31:0]      fifo_dat;
    logic             fifo_empty;
    logic             fifo_rd;
    logic             ss_start;
    logic             ss_stop;
    logic             ss_end;
    logic [31:0]      wbs_dat_i;
    logic             ss_xfer;
    logic             ss_last;
    logic [31:0]      wbs_dat_o;
    logic [23:0]      dc;
    logic             m_reset;
    logic             done_o;
    logic [1:0]       status_o;
    logic [31:0]      result_o;

    ss_stream_src #(.LEN_W(LEN_W), .TIMEOUT_CYC(16)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .desc_valid(desc_valid),
        .desc_ready(desc_ready),
        .desc_len  (desc_len),
        .desc_dc   (desc_dc),
        .abort_i   (abort_i),
        .fifo_dat  (fifo_dat),
        .fifo_empty(fifo_empty),
        .fifo_rd   (fifo_rd),
        .ss_start  (ss_start),
        .ss_stop   (ss_stop),
        .ss_end    (ss_end),
        .wbs_dat_i (wbs_dat_i),
        .ss_xfer   (ss_xfer),
        .ss_last   (ss_last),
        .wbs_dat_o (wbs_dat_o),
        .dc        (dc),
        .m_reset   (m_reset),
        .done_o    (done_o),
        .status_o  (status_o),
        .result_o  (result_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read-FIFO model: show-ahead head, pop applied shortly after the edge that saw fifo_rd.
    logic [31:0] fq[$];
    logic        hold_empty = 1'b0;
    int          fq_n       = 0;
    logic [31:0] fq_head    = '0;
    int          rd_cnt     = 0;

    assign fifo_empty = (fq_n == 0) || hold_empty;
    assign fifo_dat   = fq_head;

    task automatic fifo_refresh();
        fq_n    = fq.size();
        fq_head = (fq.size() != 0) ? fq[0] : 32'h0;
    endtask

    always @(posedge wb_clk_i) begin
        logic r;
        r = fifo_rd;
        #2;
        if (r === 1'b1) begin
            rd_cnt++;
            if (fq.size() != 0) void'(fq.pop_front());
        end
        fifo_refresh();
    end

    always @(negedge wb_clk_i) begin
        #2;
        fifo_refresh();
    end

    // Scoreboard monitor.
    logic [32:0] exp_q[$];
    logic [23:0] exp_dc   = '0;
    logic        stop_at_edge = 1'b0;
    int          xfer_cnt = 0;
    int          last_cnt = 0;
    int          done_cnt = 0;
    int          mres_cnt = 0;

    always @(posedge wb_clk_i) stop_at_edge <= ss_stop;

    always @(negedge wb_clk_i) begin
        if (done_o === 1'b1) done_cnt++;
        if (m_reset === 1'b1) mres_cnt++;
        if (ss_xfer === 1'b1) begin
            logic [32:0] e;
            xfer_cnt++;
            if (ss_last === 1'b1) last_cnt++;
            chk("xfer_under_stop", 32'(stop_at_edge), 32'd0);
            chk("dc_hold", 32'(dc), 32'(exp_dc));
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_xfer: got data %h, expected no transfer", wbs_dat_o);
            end else begin
                e = exp_q.pop_front();
                chk("xfer_data", wbs_dat_o, e[31:0]);
                chk("xfer_last", 32'(ss_last), 32'(e[32]));
            end
        end
    end

    task automatic tick();
        @(negedge wb_clk_i);
        #1;
    endtask

    task automatic push_words(input int n, input logic [31:0] w0, input logic with_last);
        for (int i = 0; i < n; i++) begin
            fq.push_back(w0 + 32'(i));
            exp_q.push_back({with_last && (i == n - 1), w0 + 32'(i)});
        end
    endtask

    task automatic send_desc(input int len, input logic [23:0] dcv);
        desc_len   = LEN_W'(len);
        desc_dc    = dcv;
        desc_valid = 1'b1;
        exp_dc     = dcv;
        chk("desc_ready_idle", 32'(desc_ready), 32'd1);
        tick();
        desc_valid = 1'b0;
    endtask

    task automatic start_pulse();
        ss_start = 1'b1;
        tick();
        ss_start = 1'b0;
    endtask

    task automatic wait_xfers(input int target);
        int n = 0;
        while (xfer_cnt < target && n < 60) begin
            tick();
            n++;
        end
        chk("xfer_count_reached", 32'(xfer_cnt >= target), 32'd1);
    endtask

    task automatic end_job(input logic [31:0] res);
        wbs_dat_i = res;
        ss_end    = 1'b1;
        tick();
        ss_end    = 1'b0;
        chk("done_pulse", 32'(done_o), 32'd1);
        chk("result", result_o, res);
        chk("status_ok", 32'(status_o), 32'd0);
        tick();
        chk("done_one_cycle", 32'(done_o), 32'd0);
        chk("ready_after_done", 32'(desc_ready), 32'd1);
    endtask

    task automatic simple_job(input int n, input logic [31:0] w0, input logic [23:0] dcv,
                              input logic [31:0] res);
        int b;
        b = xfer_cnt;
        push_words(n, w0, 1'b1);
        send_desc(n, dcv);
        tick();
        start_pulse();
        wait_xfers(b + n);
        end_job(res);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_desc_ready"}, 32'(desc_ready), 32'd1);
        chk({tag, "_ss_xfer"}, 32'(ss_xfer), 32'd0);
        chk({tag, "_ss_last"}, 32'(ss_last), 32'd0);
        chk({tag, "_m_reset"}, 32'(m_reset), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_wbs_dat_o"}, wbs_dat_o, 32'd0);
        chk({tag, "_dc"}, 32'(dc), 32'd0);
        chk({tag, "_status"}, 32'(status_o), 32'd0);
        chk({tag, "_result"}, result_o, 32'd0);
    endtask

    initial begin
        int b, bl, r0, d0, m0, n;
        wb_rst_i   = 1'b1;
        desc_valid = 1'b0;
        desc_len   = '0;
        desc_dc    = '0;
        abort_i    = 1'b0;
        ss_start   = 1'b0;
        ss_stop    = 1'b0;
        ss_end     = 1'b0;
        wbs_dat_i  = '0;

        tick();
        tick();
        chk_reset_vals("reset");
        wb_rst_i = 1'b0;
        tick();

        // Basic job: 4 words, start after 3 cycles.
        b  = xfer_cnt;
        bl = last_cnt;
        push_words(4, 32'h11, 1'b1);
        exp_q.delete();
        exp_q.push_back({1'b0, 32'h11});
        exp_q.push_back({1'b0, 32'h22});
        exp_q.push_back({1'b0, 32'h33});
        exp_q.push_back({1'b1, 32'h44});
        fq.delete();
        fq.push_back(32'h11); fq.push_back(32'h22); fq.push_back(32'h33); fq.push_back(32'h44);
        send_desc(4, 24'hA5A5A5);
        chk("ready_low_wait_start", 32'(desc_ready), 32'd0);
        chk("dc_latched", 32'(dc), 32'h00A5A5A5);
        repeat (3) tick();
        chk("no_xfer_before_start", 32'(ss_xfer), 32'd0);
        start_pulse();
        wait_xfers(b + 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("consecutive_xfer", 32'(ss_xfer), 32'd1);
        end
        end_job(32'hDEADBEEF);
        chk("basic_xfers", 32'(xfer_cnt - b), 32'd4);
        chk("basic_last_once", 32'(last_cnt - bl), 32'd1);

        // Backpressure: stop for 5 cycles after the 2nd word, FIFO intermittently empty.
        b  = xfer_cnt;
        bl = last_cnt;
        for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, 32'h101 + 32'(i)});
        fq.push_back(32'h101); fq.push_back(32'h102); fq.push_back(32'h103);
        send_desc(8, 24'h0B0B0B);
        start_pulse();
        wait_xfers(b + 2);
        ss_stop = 1'b1;
        for (int i = 0; i < 4; i++) fq.push_back(32'h104 + 32'(i));
        repeat (5) tick();
        chk("stop_held_words", 32'(xfer_cnt - b), 32'd2);
        ss_stop = 1'b0;
        tick();
        hold_empty = 1'b1;
        repeat (3) tick();
        hold_empty = 1'b0;
        repeat (8) tick();
        fq.push_back(32'h108);
        wait_xfers(b + 8);
        repeat (2) tick();
        chk("bp_xfers", 32'(xfer_cnt - b), 32'd8);
        chk("bp_last_once", 32'(last_cnt - bl), 32'd1);
        end_job(32'h12345678);

        // Zero-length descriptor.
        b  = xfer_cnt;
        r0 = rd_cnt;
        d0 = done_cnt;
        send_desc(0, 24'h000111);
        n = 0;
        while (done_o !== 1'b1 && n < 2) begin
            tick();
            n++;
        end
        chk("zero_done_seen", 32'(done_o), 32'd1);
        chk("zero_status", 32'(status_o), 32'd1);
        chk("zero_dc", 32'(dc), 32'h00000111);
        repeat (2) tick();
        chk("zero_no_rd", 32'(rd_cnt - r0), 32'd0);
        chk("zero_no_xfer", 32'(xfer_cnt - b), 32'd0);
        chk("zero_one_done", 32'(done_cnt - d0), 32'd1);
        chk("zero_status_hold", 32'(status_o), 32'd1);

        // Abort after the 3rd of 10 words.
        b = xfer_cnt;
        fq.delete();
        for (int i = 0; i < 10; i++) fq.push_back(32'h201 + 32'(i));
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 32'h201 + 32'(i)});
        send_desc(10, 24'h0C0C0C);
        chk("abort_status_cleared", 32'(status_o), 32'd0);
        start_pulse();
        wait_xfers(b + 3);
        m0 = mres_cnt;
        d0 = done_cnt;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_xfer_stop", 32'(ss_xfer), 32'd0);
        chk("abort_m_reset", 32'(m_reset), 32'd1);
        chk("abort_ready", 32'(desc_ready), 32'd1);
        tick();
        chk("abort_m_reset_pulse", 32'(m_reset), 32'd0);
        repeat (3) tick();
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_one_mreset", 32'(mres_cnt - m0), 32'd1);
        chk("abort_three_words", 32'(xfer_cnt - b), 32'd3);
        fq.delete();
        tick();
        simple_job(2, 32'h301, 24'h0E0E0E, 32'hCAFEF00D);

        // Reset while waiting for ss_end.
        b = xfer_cnt;
        push_words(1, 32'h401, 1'b1);
        send_desc(1, 24'h0D0D0D);
        start_pulse();
        wait_xfers(b + 1);
        wb_rst_i = 1'b1;
        tick();
        chk_reset_vals("midrst");
        wb_rst_i  = 1'b0;
        d0        = done_cnt;
        wbs_dat_i = 32'h00000055;
        ss_end    = 1'b1;
        repeat (3) tick();
        ss_end    = 1'b0;
        chk("midrst_end_ignored", 32'(done_cnt - d0), 32'd0);
        chk("midrst_result", result_o, 32'd0);
        simple_job(3, 32'h501, 24'h0F0F0F, 32'h600DF00D);

`ifdef SS_TIMEOUT_EN
        // Start never arrives: expiry after 16 wait cycles.
        fq.delete();
        send_desc(1, 24'h070707);
        n = 0;
        while (done_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'd16);
        chk("tmo_m_reset", 32'(m_reset), 32'd1);
        chk("tmo_status", 32'(status_o), 32'd2);
        tick();
`endif

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
